instruction_decode: RTL and testbench

- Second stage of the GCD MIPS CPU. It sits directly downstream of instruction fetch and consumes its `PC` and `IR`.
- Reads a 32×32 register file and resolves `beq`/`bne`/`j` in this stage, driving `jump`, `branch`, `jump_addr` and `branch_addr` back to fetch.
- Registers decoded operands and control into the ID/EX pipeline register for the execute stage.
- Owns the architectural register file, whose write port is driven by write-back.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/register_file.sv | 38 +++
 rtl/instruction_decode.sv | 139 +++++++++++++
 tb/tb_instruction_decode.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, ALU-op encodings and field positions for the GCD MIPS decode stage
package mips_pkg;

  localparam int RF_DEPTH = 32;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int TGT_MSB   = 25;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, 2 read / 1 write ports; REGFILE_BYPASS_EN forwards same-cycle writes
module register_file
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [RF_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_rs, fwd_rt;
  assign fwd_rs = we && (wr_addr != 5'd0) && (wr_addr == rs_addr);
  assign fwd_rt = we && (wr_addr != 5'd0) && (wr_addr == rt_addr);
  assign rs_data = (rs_addr == 5'd0) ? '0 : (fwd_rs ? wr_data : regs[rs_addr]);
  assign rt_data = (rt_addr == 5'd0) ? '0 : (fwd_rt ? wr_data : regs[rt_addr]);
`else
  // r0 is never written, but the explicit zero keeps reads correct by construction.
  assign rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
`endif

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS ID stage: decode, branch/jump resolution, ID/EX register (REGFILE_BYPASS_EN optional)
module instruction_decode
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] IR,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        jump,
  output logic [31:0] jump_addr,
  output logic        branch,
  output logic [31:0] branch_addr,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic [2:0]  ex_alu_op,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_mem_to_reg,
  output logic        illegal
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, rs_data, rt_data;

  assign opcode = IR[OP_MSB:OP_LSB];
  assign funct  = IR[FUNCT_MSB:FUNCT_LSB];
  assign rs     = IR[RS_MSB:RS_LSB];
  assign rt     = IR[RT_MSB:RT_LSB];
  assign rd     = IR[RD_MSB:RD_LSB];
  assign imm    = sign_ext16(IR[IMM_MSB:0]);

  register_file u_rf (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .we      (wb_we),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  logic       d_reg_write, d_mem_read, d_mem_write, d_alu_src, d_mem_to_reg, d_illegal;
  logic [4:0] d_dest;
  alu_op_e    d_alu_op;

  always_comb begin
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_mem_to_reg = 1'b0;
    d_illegal    = 1'b0;
    d_dest       = 5'd0;
    d_alu_op     = ALU_ADD;
    jump         = 1'b0;
    branch       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_dest      = rd;
        d_reg_write = 1'b1;
        case (funct)
          FN_ADD:  d_alu_op = ALU_ADD;
          FN_SUB:  d_alu_op = ALU_SUB;
          FN_AND:  d_alu_op = ALU_AND;
          FN_OR:   d_alu_op = ALU_OR;
          FN_SLT:  d_alu_op = ALU_SLT;
          default: begin
            d_illegal   = 1'b1;
            d_reg_write = 1'b0;
            d_dest      = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        d_dest      = rt;
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_LW: begin
        d_dest       = rt;
        d_alu_src    = 1'b1;
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BEQ:  branch = (rs_data == rt_data);
      OP_BNE:  branch = (rs_data != rt_data);
      OP_J:    jump   = 1'b1;
      default: d_illegal = 1'b1;
    endcase
  end

  // PC already points at the delay slot, so offsets are relative to it.
  assign branch_addr = PC + {imm[29:0], 2'b00};
  assign jump_addr   = {PC[31:28], IR[TGT_MSB:0], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_dest       <= '0;
      ex_alu_op     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      ex_rs_data    <= rs_data;
      ex_rt_data    <= rt_data;
      ex_imm        <= imm;
      ex_dest       <= d_dest;
      ex_alu_op     <= d_alu_op;
      ex_reg_write  <= d_reg_write;
      ex_mem_read   <= d_mem_read;
      ex_mem_write  <= d_mem_write;
      ex_alu_src    <= d_alu_src;
      ex_mem_to_reg <= d_mem_to_reg;
      illegal       <= illegal | d_illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed self-checking bench for instruction_decode
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, IR;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump, branch;
  logic [31:0] jump_addr, branch_addr;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg, illegal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk(clk), .rst(rst), .PC(PC), .IR(IR),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_addr(branch_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  function automatic logic [5:0] ctrl_bits();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg, illegal};
  endfunction

  logic [31:0] same_cycle_exp;

  initial begin
    rst = 1'b0; PC = '0; IR = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) tick();
    check("rst_ctrl", {26'd0, ctrl_bits()}, 32'd0);
    check("rst_rs", ex_rs_data, 32'd0);
    check("rst_imm", ex_imm, 32'd0);
    check("rst_dest_op", {24'd0, ex_dest, ex_alu_op}, 32'd0);

    rst = 1'b1;
    IR = 32'h00A63820;                       // add r7,r5,r6
    tick();
    check("rf_reset_rs", ex_rs_data, 32'd0);
    check("rf_reset_rt", ex_rt_data, 32'd0);
    check("add_dest", {27'd0, ex_dest}, 32'd7);
    check("add_ctrl", {26'd0, ctrl_bits()}, 32'b100000);

    wb_write(5'd1, 32'd5);
    IR = 32'h2022FFFD;                       // addi r2,r1,-3
    tick();
    check("addi_rs", ex_rs_data, 32'd5);
    check("addi_imm", ex_imm, 32'hFFFFFFFD);
    check("addi_dest", {27'd0, ex_dest}, 32'd2);
    check("addi_ctrl", {26'd0, ctrl_bits()}, 32'b100100);
    check("addi_op", {29'd0, ex_alu_op}, 32'd0);

    IR = 32'h8C240008;                       // lw r4,8(r1)
    tick();
    check("lw_ctrl", {26'd0, ctrl_bits()}, 32'b110110);
    check("lw_dest", {27'd0, ex_dest}, 32'd4);

    IR = 32'hAC240008;                       // sw r4,8(r1)
    tick();
    check("sw_ctrl", {26'd0, ctrl_bits()}, 32'b001100);

    IR = 32'h00212822;                       // sub r5,r1,r1
    tick();
    check("sub_op", {29'd0, ex_alu_op}, 32'd1);
    IR = 32'h00212824;                       // and
    tick();
    check("and_op", {29'd0, ex_alu_op}, 32'd2);
    IR = 32'h00212825;                       // or
    tick();
    check("or_op", {29'd0, ex_alu_op}, 32'd3);
    IR = 32'h0021282A;                       // slt
    tick();
    check("slt_op", {29'd0, ex_alu_op}, 32'd4);
    check("slt_dest", {27'd0, ex_dest}, 32'd5);

    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    PC = 32'h20; IR = 32'h10220004;          // beq r1,r2,+4
    #1;
    check("beq_taken", {31'd0, branch}, 32'd1);
    check("beq_addr", branch_addr, 32'h30);
    check("beq_nojump", {31'd0, jump}, 32'd0);
    tick();
    check("beq_bubble", {26'd0, ctrl_bits()}, 32'd0);

    wb_write(5'd2, 32'd8);
    #1;
    check("beq_not_taken", {31'd0, branch}, 32'd0);
    IR = 32'h14220004;                       // bne r1,r2,+4
    #1;
    check("bne_taken", {31'd0, branch}, 32'd1);
    PC = 32'h4; IR = 32'h1422FFFE;           // bne offset -2 wraps below zero
    #1;
    check("bne_wrap_addr", branch_addr, 32'hFFFFFFFC);

    PC = 32'h10000008; IR = 32'h08000010;    // j 0x40
    #1;
    check("j_jump", {31'd0, jump}, 32'd1);
    check("j_addr", jump_addr, 32'h10000040);
    check("j_nobranch", {31'd0, branch}, 32'd0);
    tick();
    check("j_bubble", {26'd0, ctrl_bits()}, 32'd0);

    wb_write(5'd3, 32'd1);
    IR = 32'h00603020;                       // add r6,r3,r0
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'd9;
`else
    same_cycle_exp = 32'd1;
`endif
    tick();
    wb_we = 1'b0;
    check("same_cycle_rs", ex_rs_data, same_cycle_exp);
    tick();
    check("after_write_rs", ex_rs_data, 32'd9);

    IR = 32'h00001820;                       // add r3,r0,r0
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    wb_we = 1'b0;
    check("r0_same_cycle", ex_rs_data, 32'd0);
    tick();
    check("r0_after_write", ex_rs_data, 32'd0);

    IR = 32'hFC000000;                       // opcode 0x3F
    tick();
    check("illegal_set", {31'd0, illegal}, 32'd1);
    check("illegal_bubble", {31'd0, ex_reg_write}, 32'd0);
    IR = 32'h2022FFFD;
    tick();
    tick();
    check("illegal_sticky", {31'd0, illegal}, 32'd1);

    #2 rst = 1'b0;
    #1;
    check("async_rst_illegal", {31'd0, illegal}, 32'd0);
    check("async_rst_ctrl", {26'd0, ctrl_bits()}, 32'd0);
    check("async_rst_rs", ex_rs_data, 32'd0);
    tick();
    rst = 1'b1;
    IR = 32'h2022FFFD;
    tick();
    check("rf_cleared_r1", ex_rs_data, 32'd0);

    IR = 32'h00212821;                       // R-type with unknown funct
    tick();
    check("illegal_funct", {31'd0, illegal}, 32'd1);
    check("illegal_funct_bubble", {31'd0, ex_reg_write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
